softmax_arbiter: RTL and testbench

SOFTMAX_ARBITER -- requirements
Module: softmax_arbiter

---
 rtl/softmax_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_softmax_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_arbiter
//  Description : Round-robin front end for a fixed-latency softmax core with
//                two requesters, tag-tracked result routing and flush/drain.
//  Revision    : 1.0  initial release
// ============================================================================
module softmax_arbiter #(
    parameter int N   = 8,
    parameter int LAT = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [N*16-1:0] req0_x_flat,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [N*16-1:0] req1_x_flat,
    output logic            req1_ready,
    input  logic            flush,
    output logic            en,
    output logic            valid_in,
    output logic [N*16-1:0] in_x_flat,
    input  logic            core_valid_out,
    input  logic [N*16-1:0] core_y_flat,
    output logic            out0_valid,
    output logic [N*16-1:0] out0_y_flat,
    output logic            out1_valid,
    output logic [N*16-1:0] out1_y_flat,
    output logic            busy,
    output logic            drained,
    output logic            err
);

    localparam int         c_VEC_W    = N * 16;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last;
    logic               r_valid_in;
    logic [c_VEC_W-1:0] r_in_x;
    logic               r_in_id;
    logic [LAT-1:0]     r_tag_v;
    logic [LAT-1:0]     r_tag_id;
    logic [LAT-1:0]     w_tag_v_nxt;
    logic [LAT-1:0]     w_tag_id_nxt;
    logic               r_en;
    logic               r_out0_v;
    logic               r_out1_v;
    logic [c_VEC_W-1:0] r_out0_y;
    logic [c_VEC_W-1:0] r_out1_y;
    logic               r_drained;
    logic               w_drained_nxt;
    logic               r_err;
    logic               r_flush_q;

    logic               w_any_req;
    logic               w_gnt;
    logic               w_accept_ok;
    logic               w_xfer;
    logic [c_VEC_W-1:0] w_win_x;
    logic               w_pipe_empty;
    logic               w_exp_v;
    logic               w_exp_id;
    logic               w_hit;
    logic               w_mismatch;
    logic               w_en_nxt;

    // Round-robin: a lone requester always wins; on a tie the one that did
    // not win last time goes first.
    assign w_any_req   = req0_valid | req1_valid;
    assign w_gnt       = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_accept_ok = ~flush & (r_state != c_ST_DRAIN);
    assign req0_ready  = w_accept_ok & req0_valid & ~w_gnt;
    assign req1_ready  = w_accept_ok & req1_valid & w_gnt;
    assign w_xfer      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_win_x     = w_gnt ? req1_x_flat : req0_x_flat;

    // Tag stage 0 follows valid_in by one cycle so the last stage lines up
    // with the core's result strobe LAT cycles after valid_in.
    generate
        if (LAT > 1) begin : g_tag_shift
            assign w_tag_v_nxt  = {r_tag_v[LAT-2:0],  r_valid_in};
            assign w_tag_id_nxt = {r_tag_id[LAT-2:0], r_in_id};
        end else begin : g_tag_single
            assign w_tag_v_nxt  = r_valid_in;
            assign w_tag_id_nxt = r_in_id;
        end
    endgenerate

    assign w_exp_v      = r_tag_v[LAT-1];
    assign w_exp_id     = r_tag_id[LAT-1];
    assign w_hit        = w_exp_v & core_valid_out;
    assign w_mismatch   = w_exp_v ^ core_valid_out;
    assign w_pipe_empty = ~r_valid_in & ~(|r_tag_v);
    assign w_en_nxt     = w_xfer | (|w_tag_v_nxt);

    always_comb begin
        w_state_nxt   = r_state;
        w_drained_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (flush) begin
                    // Level flush held across IDLE must not re-pulse drained.
                    if (w_pipe_empty) begin
                        w_drained_nxt = ~r_flush_q;
                    end else begin
                        w_state_nxt = c_ST_DRAIN;
                    end
                end else if (w_any_req) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (flush) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_drained_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_last     <= 1'b1;
            r_valid_in <= 1'b0;
            r_in_x     <= '0;
            r_in_id    <= 1'b0;
            r_tag_v    <= '0;
            r_tag_id   <= '0;
            r_en       <= 1'b0;
            r_out0_v   <= 1'b0;
            r_out1_v   <= 1'b0;
            r_out0_y   <= '0;
            r_out1_y   <= '0;
            r_drained  <= 1'b0;
            r_err      <= 1'b0;
            r_flush_q  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid_in <= w_xfer;
            if (w_xfer) begin
                r_last  <= w_gnt;
                r_in_x  <= w_win_x;
                r_in_id <= w_gnt;
            end
            r_tag_v    <= w_tag_v_nxt;
            r_tag_id   <= w_tag_id_nxt;
            r_en       <= w_en_nxt;
            r_out0_v   <= w_hit & ~w_exp_id;
            r_out1_v   <= w_hit & w_exp_id;
            if (w_hit & ~w_exp_id) begin
                r_out0_y <= core_y_flat;
            end
            if (w_hit & w_exp_id) begin
                r_out1_y <= core_y_flat;
            end
            r_err      <= r_err | w_mismatch;
            r_drained  <= w_drained_nxt;
            r_flush_q  <= flush;
        end
    end

    assign en          = r_en;
    assign valid_in    = r_valid_in;
    assign in_x_flat   = r_in_x;
    assign out0_valid  = r_out0_v;
    assign out1_valid  = r_out1_v;
    assign out0_y_flat = r_out0_y;
    assign out1_y_flat = r_out1_y;
    assign drained     = r_drained;
    assign err         = r_err;
    assign busy        = (r_state != c_ST_IDLE) | r_valid_in | (|r_tag_v)
                         | r_out0_v | r_out1_v;

endmodule
`default_nettype wire

// File: tb/tb_softmax_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_arbiter
//  Description : Directed self-checking bench for softmax_arbiter with a
//                fixed-latency core model (result = input XOR mask).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_softmax_arbiter;

    localparam int N   = 8;
    localparam int LAT = 6;
    localparam int W   = N * 16;
    localparam logic [W-1:0] MASK = {8{16'h5A3C}};
    localparam logic [W-1:0] X0   = 128'h061D_2A4F_F0C8_7FFF_8000_0001_C3A5_F5BE;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_x_flat, req1_x_flat;
    logic         flush, en, valid_in;
    logic [W-1:0] in_x_flat;
    logic         core_valid_out;
    logic [W-1:0] core_y_flat;
    logic         out0_valid, out1_valid;
    logic [W-1:0] out0_y_flat, out1_y_flat;
    logic         busy, drained, err;

    int npass = 0;
    int ntot  = 0;
    int ndr   = 0;

    always #5 clk = ~clk;

    softmax_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_x_flat(req0_x_flat), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x_flat(req1_x_flat), .req1_ready(req1_ready),
        .flush(flush), .en(en), .valid_in(valid_in), .in_x_flat(in_x_flat),
        .core_valid_out(core_valid_out), .core_y_flat(core_y_flat),
        .out0_valid(out0_valid), .out0_y_flat(out0_y_flat),
        .out1_valid(out1_valid), .out1_y_flat(out1_y_flat),
        .busy(busy), .drained(drained), .err(err)
    );

    // Core model: not reset, so beats in flight across a reset still emerge.
    logic [LAT-1:0] pv = '0;
    logic [W-1:0]   px [LAT];
    logic           inject;

    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], valid_in};
        px[0] <= in_x_flat;
        for (int k = 1; k < LAT; k++) px[k] <= px[k-1];
    end

    assign core_valid_out = pv[LAT-1] | inject;
    assign core_y_flat    = px[LAT-1] ^ MASK;

    function automatic logic [W-1:0] cv(input int k, input int c);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'(16'h1000 * (k + 1) + 16'h0010 * i + c);
        return v;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x_flat = '0; req1_x_flat = '0; flush = 1'b0; inject = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk1("rst_en", en, 1'b0);
        chk1("rst_valid_in", valid_in, 1'b0);
        chk1("rst_out0_valid", out0_valid, 1'b0);
        chk1("rst_out1_valid", out1_valid, 1'b0);
        chk1("rst_drained", drained, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chkv("rst_in_x", in_x_flat, '0);
        chkv("rst_out0_y", out0_y_flat, '0);
        chkv("rst_out1_y", out1_y_flat, '0);
        rst = 1'b0;

        // ---------------- single beat ----------------
        req0_valid = 1'b1; req0_x_flat = X0;
        #1;
        chk1("single_req0_ready", req0_ready, 1'b1);
        chk1("single_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk1("single_valid_in", valid_in, 1'b1);
        chkv("single_in_x", in_x_flat, X0);
        chk1("single_en", en, 1'b1);
        chk1("single_busy", busy, 1'b1);
        @(negedge clk);
        chk1("single_valid_in_drop", valid_in, 1'b0);
        chkv("single_in_x_hold", in_x_flat, X0);
        repeat (LAT - 1) @(negedge clk);
        chk1("single_out0_early", out0_valid, 1'b0);
        @(negedge clk);
        chk1("single_out0_valid", out0_valid, 1'b1);
        chkv("single_out0_y", out0_y_flat, X0 ^ MASK);
        chk1("single_out1_valid", out1_valid, 1'b0);
        chk1("single_err", err, 1'b0);
        @(negedge clk);
        chk1("single_out0_pulse", out0_valid, 1'b0);
        chkv("single_out0_y_hold", out0_y_flat, X0 ^ MASK);
        chk1("single_en_off", en, 1'b0);

        // ---------------- contention ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 1 && c <= 6) begin
                chk1("cont_valid_in", valid_in, 1'b1);
                chkv("cont_in_x", in_x_flat, cv((c - 1) % 2, c - 1));
            end
            if (c >= 8 && c <= 13) begin
                chk1("cont_out0_valid", out0_valid, ((c - 8) % 2) == 0);
                chk1("cont_out1_valid", out1_valid, ((c - 8) % 2) == 1);
                if (((c - 8) % 2) == 0) chkv("cont_out0_y", out0_y_flat, cv(0, c - 8) ^ MASK);
                else                    chkv("cont_out1_y", out1_y_flat, cv(1, c - 8) ^ MASK);
            end
            chk1("cont_onehot", out0_valid & out1_valid, 1'b0);
            req0_valid = (c < 6); req1_valid = (c < 6);
            req0_x_flat = cv(0, c); req1_x_flat = cv(1, c);
            #1;
            if (c < 6) begin
                chk1("cont_req0_ready", req0_ready, (c % 2) == 0);
                chk1("cont_req1_ready", req1_ready, (c % 2) == 1);
            end
        end

        // ---------------- flush mid-stream ----------------
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            if (c >= 8 && c <= 10) begin
                chk1("flush_out0_valid", out0_valid, 1'b1);
                chkv("flush_out0_y", out0_y_flat, cv(2, c - 8) ^ MASK);
                chk1("flush_out1_valid", out1_valid, 1'b0);
            end
            if (c == 9)  chk1("flush_en_on", en, 1'b1);
            if (c == 10) begin
                chk1("flush_en_off", en, 1'b0);
                chk1("flush_busy_drain", busy, 1'b1);
            end
            if (c == 11) begin
                chk1("flush_drained", drained, 1'b1);
                chk1("flush_busy_idle", busy, 1'b0);
            end
            if (c == 12) chk1("flush_busy_idle2", busy, 1'b0);
            if (drained) ndr++;
            req0_valid = (c <= 3); req0_x_flat = cv(2, c);
            flush = (c >= 3 && c <= 11);
            #1;
            if (c < 3) chk1("flush_ready_pre", req0_ready, 1'b1);
            if (c >= 3 && c <= 5) chk1("flush_ready_blocked", req0_ready, 1'b0);
        end
        chkv("flush_drained_once", W'(ndr), W'(1));

        // ---------------- idle flush ----------------
        @(negedge clk);
        chk1("iflush_busy0", busy, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk1("iflush_drained", drained, 1'b1);
        chk1("iflush_busy1", busy, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        chk1("iflush_drained_pulse", drained, 1'b0);
        chk1("iflush_busy2", busy, 1'b0);

        // ---------------- core fault ----------------
        @(negedge clk);
        chk1("fault_err_pre", err, 1'b0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        chk1("fault_err", err, 1'b1);
        chk1("fault_out0", out0_valid, 1'b0);
        chk1("fault_out1", out1_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk1("fault_err_sticky", err, 1'b1);

        // ---------------- reset mid-flight ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rmid_err_cleared", err, 1'b0);
        req0_valid = 1'b1; req0_x_flat = cv(3, 0);
        @(negedge clk);
        req0_x_flat = cv(3, 1);
        chk1("rmid_valid_in1", valid_in, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0; rst = 1'b1;
        chkv("rmid_in_x2", in_x_flat, cv(3, 1));
        @(negedge clk);
        rst = 1'b0;
        chk1("rmid_valid_in", valid_in, 1'b0);
        chk1("rmid_en", en, 1'b0);
        chk1("rmid_busy", busy, 1'b0);
        chk1("rmid_err", err, 1'b0);
        chkv("rmid_in_x", in_x_flat, '0);
        for (int c = 4; c <= 12; c++) begin
            @(negedge clk);
            chk1("rmid_out0", out0_valid, 1'b0);
            chk1("rmid_out1", out1_valid, 1'b0);
            if (c == 7) chk1("rmid_err_before", err, 1'b0);
            if (c == 8) chk1("rmid_err_after", err, 1'b1);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
